game_player: RTL and testbench

- Scripted stimulus driver for the maze-game FSM. It is the driving end of the n/s/e/w/win/die interface.
- Holds a short move script loaded through a write port. On start, it replays the script into the game one move per cycle.
- Watches win/die and stops on the first outcome. It reports the result, the number of moves issued and a 7-bit response signature.
- Used for on-chip self-test of the game and as a reusable player in system benches.

---
 rtl/game_player.sv | 204 ++++++++++++++++++++
 tb/tb_game_player.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_player.sv
// game_player: scripted driver for the maze-game FSM.
//
// A move script is written into a small memory while idle. A start pulse
// replays it into the game one move per cycle on n/s/e/w. Every play cycle
// samples win/die and folds it into a 7-bit signature. Replay stops on the
// first outcome, or when the script has been played out and two drain cycles
// have gone by.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; the script may be written; waiting for start
// PLAY  | one script move is issued per edge; win/die are sampled
// DRAIN | two edges with no move; catches the outcome of the last moves
// DONE  | result/moves/sig are held; start replays the script
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   wr_en            script write strobe (honoured in IDLE only)
//   wr_addr[AW-1:0]  script write address
//   wr_dir[3:0]      move to store, {n,s,e,w}
//   start            begin replay (honoured in IDLE or DONE only)
//   len[AW:0]        number of script entries to play, 0..DEPTH
//   win, die         outcome inputs from the game
//   n, s, e, w       registered move outputs to the game
//   busy             high in PLAY and DRAIN
//   done             high in DONE until the next accepted start
//   result[1:0]      00 none, 01 died, 10 won, 11 script exhausted
//   moves[AW:0]      number of moves issued
//   sig[6:0]         response signature

module game_player #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_dir,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          win,
    input  logic          die,
    output logic          n,
    output logic          s,
    output logic          e,
    output logic          w,
    output logic          busy,
    output logic          done,
    output logic [1:0]    result,
    output logic [AW:0]   moves,
    output logic [6:0]    sig
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] IDX_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] IDX_ZERO = '0;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_DIED = 2'b01;
    localparam logic [1:0] RES_WON  = 2'b10;
    localparam logic [1:0] RES_EXH  = 2'b11;

    state_t      state_q;
    logic [3:0]  mem_q [DEPTH];
    logic [3:0]  dir_q;
    logic [AW:0] idx_q;
    logic [AW:0] len_q;
    logic [AW:0] moves_q;
    logic [6:0]  sig_q;
    logic [1:0]  result_q;
    logic        busy_q;
    logic        done_q;
    logic        drain_cnt_q;

    logic [6:0]  sig_t;
    logic [6:0]  sig_d;
    logic [3:0]  rd_dir;
    logic        start_ok;

    // Signature step: fold {win,die} into the low bits, then shift left with
    // the XOR of the two top bits fed back into bit 0.
    assign sig_t = sig_q ^ {5'b0, win, die};
    assign sig_d = {sig_t[5:0], sig_t[6] ^ sig_t[5]};

    assign rd_dir   = mem_q[idx_q[AW-1:0]];
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // The script memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            mem_q[wr_addr] <= wr_dir;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= 4'b0000;
            idx_q       <= IDX_ZERO;
            len_q       <= IDX_ZERO;
            moves_q     <= IDX_ZERO;
            sig_q       <= 7'h00;
            result_q    <= RES_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_cnt_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    dir_q <= 4'b0000;
                    if (start_ok) begin
                        // len is captured so a change mid-run cannot push
                        // idx past the end of the script being played.
                        len_q <= len;
                        sig_q <= 7'h00;
                        if (len != IDX_ZERO) begin
                            state_q  <= ST_PLAY;
                            dir_q    <= mem_q[0];
                            idx_q    <= IDX_ONE;
                            moves_q  <= IDX_ONE;
                            result_q <= RES_NONE;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                        end else begin
                            state_q  <= ST_DONE;
                            idx_q    <= IDX_ZERO;
                            moves_q  <= IDX_ZERO;
                            result_q <= RES_EXH;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    sig_q <= sig_d;
                    if (win) begin
                        state_q  <= ST_DONE;
                        dir_q    <= 4'b0000;
                        result_q <= RES_WON;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (die) begin
                        state_q  <= ST_DONE;
                        dir_q    <= 4'b0000;
                        result_q <= RES_DIED;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (idx_q < len_q) begin
                        dir_q   <= rd_dir;
                        idx_q   <= idx_q + IDX_ONE;
                        moves_q <= moves_q + IDX_ONE;
                    end else begin
                        state_q     <= ST_DRAIN;
                        dir_q       <= 4'b0000;
                        drain_cnt_q <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    sig_q <= sig_d;
                    dir_q <= 4'b0000;
                    if (win) begin
                        state_q  <= ST_DONE;
                        result_q <= RES_WON;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (die) begin
                        state_q  <= ST_DONE;
                        result_q <= RES_DIED;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (drain_cnt_q) begin
                        state_q  <= ST_DONE;
                        result_q <= RES_EXH;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign n      = dir_q[3];
    assign s      = dir_q[2];
    assign e      = dir_q[1];
    assign w      = dir_q[0];
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign moves  = moves_q;
    assign sig    = sig_q;

endmodule

// File: tb/tb_game_player.sv
// Testbench for game_player: directed scenarios followed by randomized
// scripts and outcome schedules, checked against a behavioural model.

module tb_game_player;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_dir  = 4'b0000;
    logic          start   = 1'b0;
    logic [AW:0]   len     = '0;
    logic          win     = 1'b0;
    logic          die     = 1'b0;
    logic          n, s, e, w;
    logic          busy, done;
    logic [1:0]    result;
    logic [AW:0]   moves;
    logic [6:0]    sig;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] script_m [DEPTH];
    bit         ws [40];
    bit         ds [40];

    game_player #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dir  (wr_dir),
        .start   (start),
        .len     (len),
        .win     (win),
        .die     (die),
        .n       (n),
        .s       (s),
        .e       (e),
        .w       (w),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .moves   (moves),
        .sig     (sig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/dir"},    {28'd0, n, s, e, w}, 32'd0);
        check({tag, "/busy"},   {31'd0, busy},       32'd0);
        check({tag, "/done"},   {31'd0, done},       32'd0);
        check({tag, "/result"}, {30'd0, result},     32'd0);
        check({tag, "/moves"},  {27'd0, moves},      32'd0);
        check({tag, "/sig"},    {25'd0, sig},        32'd0);
    endtask

    task automatic write_mem(input int addr, input logic [3:0] dir);
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_dir  = dir;
        script_m[addr] = dir;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 40; i++) begin
            ws[i] = 1'b0;
            ds[i] = 1'b0;
        end
    endtask

    // Replays a script of length ln. ws[k]/ds[k] give win/die seen at the
    // k-th sampling edge after the start edge. If wr_j >= 0, a write of 1111
    // to address 2 is attempted during the run; it must have no effect.
    task automatic run(input string tag, input int ln, input int wr_j);
        int         exp_moves;
        int         exp_res;
        int         last;
        logic [6:0] exp_sig;
        logic [6:0] t;

        // Reference: walk the sampling edges, stop at the first outcome.
        exp_sig   = 7'h00;
        exp_moves = 0;
        exp_res   = 3;
        last      = 0;
        if (ln != 0) begin
            exp_moves = 1;
            last      = ln + 2;
            for (int k = 1; k <= ln + 2; k++) begin
                t       = exp_sig ^ {5'b0, ws[k], ds[k]};
                exp_sig = {t[5:0], t[6] ^ t[5]};
                if (ws[k]) begin
                    exp_res = 2; last = k; break;
                end else if (ds[k]) begin
                    exp_res = 1; last = k; break;
                end else if (k < ln) begin
                    exp_moves++;
                end
            end
        end

        len   = ln[AW:0];
        win   = 1'b0;
        die   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < last; j++) begin
            check({tag, "/dir"},  {28'd0, n, s, e, w}, (j < ln) ? {28'd0, script_m[j]} : 32'd0);
            check({tag, "/busy"}, {31'd0, busy}, 32'd1);
            check({tag, "/done"}, {31'd0, done}, 32'd0);
            win     = ws[j + 1];
            die     = ds[j + 1];
            wr_en   = (j == wr_j);
            wr_addr = 4'd2;
            wr_dir  = 4'hF;
            @(posedge clk); #1;
        end
        win   = 1'b0;
        die   = 1'b0;
        wr_en = 1'b0;
        check({tag, "/end_done"},   {31'd0, done},       32'd1);
        check({tag, "/end_busy"},   {31'd0, busy},       32'd0);
        check({tag, "/end_dir"},    {28'd0, n, s, e, w}, 32'd0);
        check({tag, "/end_result"}, {30'd0, result},     exp_res);
        check({tag, "/end_moves"},  {27'd0, moves},      exp_moves);
        check({tag, "/end_sig"},    {25'd0, sig},        {25'd0, exp_sig});
        @(posedge clk); #1;
        check({tag, "/hold_done"},  {31'd0, done},       32'd1);
        check({tag, "/hold_dir"},   {28'd0, n, s, e, w}, 32'd0);
    endtask

    initial begin
        int ln;
        int r;
        int k;

        // Test 1: reset
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("t1_in_reset");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_quiet("t1_idle");
        end

        // Test 2: full script, no outcome
        write_mem(0, 4'b1000);
        write_mem(1, 4'b0010);
        write_mem(2, 4'b0100);
        clear_sched();
        run("t2", 3, -1);
        check("t2/moves_const", {27'd0, moves}, 32'd3);

        // Test 3: die at the second sampling edge
        clear_sched();
        ds[2] = 1'b1;
        run("t3", 3, -1);
        check("t3/sig_const", {25'd0, sig}, 32'h02);

        // Test 4: win and die together at the first sampling edge
        clear_sched();
        ws[1] = 1'b1;
        ds[1] = 1'b1;
        run("t4", 3, -1);
        check("t4/sig_const", {25'd0, sig}, 32'h06);

        // Test 5: empty script, then a write attempted mid-play
        clear_sched();
        run("t5_len0", 0, -1);
        run("t5_wr_play", 3, 0);
        run("t5_replay", 3, -1);

        // Test 6: asynchronous reset mid-play
        clear_sched();
        len   = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("t6/dir_before", {28'd0, n, s, e, w}, 32'b0010);
        #2 reset = 1'b0;
        #1;
        check_quiet("t6_async");
        #1 reset = 1'b1;
        @(posedge clk); #1;
        run("t6_restart", 3, -1);

        // Randomized scripts and outcome schedules
        for (int it = 0; it < 12; it++) begin
            reset = 1'b0;
            #2 reset = 1'b1;
            @(posedge clk); #1;
            ln = $urandom_range(0, DEPTH);
            for (int a = 0; a < ln; a++) begin
                write_mem(a, 4'($urandom_range(0, 15)));
            end
            clear_sched();
            r = $urandom_range(0, 3);
            k = $urandom_range(1, ln + 2);
            if (r == 1) ws[k] = 1'b1;
            if (r == 2) ds[k] = 1'b1;
            if (r == 3) begin
                ws[k] = 1'b1;
                ds[k] = 1'b1;
            end
            run($sformatf("rnd%0d", it), ln, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
